// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared multiply opcodes, FSM encoding and width default
package mul_pkg;

  localparam int MUL_DATA_WIDTH = 32;

  localparam logic [1:0] MUL_U_IMM = 2'd0;
  localparam logic [1:0] MUL_U_REG = 2'd1;
  localparam logic [1:0] MUL_S_IMM = 2'd2;
  localparam logic [1:0] MUL_S_REG = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    WB   = 2'd3
  } mul_state_t;

endpackage

// File: rtl/mul_operand_prep.sv
// rtl/mul_operand_prep.sv - operand B select/extend, operand magnitudes and result sign
module mul_operand_prep
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = MUL_DATA_WIDTH,
  parameter int IMM_WIDTH  = 16
) (
  input  logic [1:0]            mul_type,
  input  logic [DATA_WIDTH-1:0] src1_data,
  input  logic [DATA_WIDTH-1:0] src2_data,
  input  logic [IMM_WIDTH-1:0]  imm,
  output logic [DATA_WIDTH-1:0] a_mag,
  output logic [DATA_WIDTH-1:0] b_mag,
  output logic                  sign
);

  logic                  is_signed;
  logic [DATA_WIDTH-1:0] b_op;
  logic                  a_neg;
  logic                  b_neg;

  always_comb begin
    is_signed = mul_type[1];
    // Immediate is sign-extended only for the signed immediate form.
    if (mul_type[0]) begin
      b_op = src2_data;
    end else begin
      b_op = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1] & is_signed}}, imm};
    end
    a_neg = is_signed & src1_data[DATA_WIDTH-1];
    b_neg = is_signed & b_op[DATA_WIDTH-1];
    // Negating the most negative value wraps to 2^(W-1), which is the correct unsigned magnitude.
    a_mag = a_neg ? -src1_data : src1_data;
    b_mag = b_neg ? -b_op : b_op;
    sign  = a_neg ^ b_neg;
  end

endmodule

// File: rtl/mul_ucode_sequencer.sv
// rtl/mul_ucode_sequencer.sv - radix-2 shift-add multiply sequencer with pipeline stall and writeback
module mul_ucode_sequencer
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = MUL_DATA_WIDTH,
  parameter int IMM_WIDTH  = 16,
  parameter int REG_AW     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mul_trigger,
  input  logic [1:0]            mul_type,
  input  logic [REG_AW-1:0]     dest_reg,
  input  logic [DATA_WIDTH-1:0] src1_data,
  input  logic [DATA_WIDTH-1:0] src2_data,
  input  logic [IMM_WIDTH-1:0]  imm,
  output logic                  stall,
  output logic                  busy,
  output logic                  rf_we,
  output logic [REG_AW-1:0]     rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [DATA_WIDTH-1:0] prod_hi,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  mul_state_t              state_q, state_d;
  logic [2*DATA_WIDTH-1:0] acc_q;
  logic [2*DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [CW-1:0]           cnt_q;
  logic                    sign_q;
  logic [REG_AW-1:0]       dest_q;

  logic [DATA_WIDTH-1:0]   a_mag;
  logic [DATA_WIDTH-1:0]   b_mag;
  logic                    sign;

  mul_operand_prep #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMM_WIDTH  (IMM_WIDTH)
  ) u_prep (
    .mul_type  (mul_type),
    .src1_data (src1_data),
    .src2_data (src2_data),
    .imm       (imm),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .sign      (sign)
  );

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    stall   = 1'b0;
    rf_we   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        stall = mul_trigger;
        if (mul_trigger) state_d = CALC;
      end
      CALC: begin
        busy  = 1'b1;
        stall = 1'b1;
        if (cnt_q == CNT_LAST) state_d = SIGN;
      end
      SIGN: begin
        busy    = 1'b1;
        stall   = 1'b1;
        state_d = WB;
      end
      WB: begin
        // Stall drops here so decode advances on the edge that ends the writeback.
        busy    = 1'b1;
        rf_we   = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      dest_q   <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      prod_hi  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (mul_trigger) begin
            dest_q <= dest_reg;
            a_q    <= {{DATA_WIDTH{1'b0}}, a_mag};
            b_q    <= b_mag;
            sign_q <= sign;
            acc_q  <= '0;
            cnt_q  <= '0;
          end
        end
        CALC: begin
          // a_q carries A<<cnt so each step is a single add.
          if (b_q[0]) acc_q <= acc_q + a_q;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
        end
        SIGN: begin
          {prod_hi, rf_wdata} <= sign_q ? -acc_q : acc_q;
          rf_waddr            <= dest_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_ucode_sequencer.sv
// tb/tb_mul_ucode_sequencer.sv - self-checking bench: vector table, scoreboard, busy-trigger and reset corners
module tb_mul_ucode_sequencer;

  localparam int DW  = 32;
  localparam int IW  = 16;
  localparam int AW  = 4;
  localparam int LAT = DW + 2;

  logic          clk;
  logic          rst;
  logic          mul_trigger;
  logic [1:0]    mul_type;
  logic [AW-1:0] dest_reg;
  logic [DW-1:0] src1_data;
  logic [DW-1:0] src2_data;
  logic [IW-1:0] imm;
  logic          stall;
  logic          busy;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] prod_hi;
  logic          done;

  mul_ucode_sequencer #(.DATA_WIDTH(DW), .IMM_WIDTH(IW), .REG_AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .mul_trigger (mul_trigger),
    .mul_type    (mul_type),
    .dest_reg    (dest_reg),
    .src1_data   (src1_data),
    .src2_data   (src2_data),
    .imm         (imm),
    .stall       (stall),
    .busy        (busy),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .prod_hi     (prod_hi),
    .done        (done)
  );

  typedef struct {
    logic [1:0]    typ;
    logic [AW-1:0] dest;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [IW-1:0] im;
    logic [DW-1:0] exp_lo;
    logic [DW-1:0] exp_hi;
  } vec_t;

  typedef struct {
    logic [AW-1:0] dest;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    int            acc_cyc;
  } sb_t;

  vec_t vecs[9];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   we_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] typ, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b, input logic [IW-1:0] im);
    logic [DW-1:0] bop;
    case (typ)
      2'd0:    bop = {{(DW-IW){1'b0}}, im};
      2'd2:    bop = {{(DW-IW){im[IW-1]}}, im};
      default: bop = b;
    endcase
    if (typ[1]) return $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{bop[DW-1]}}, bop});
    return {{DW{1'b0}}, a} * {{DW{1'b0}}, bop};
  endfunction

  always @(negedge clk) begin
    if (!rst && rf_we) begin
      sb_t e;
      we_count++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: rf_we=1 with no pending op, waddr=%0d (cycle %0d)", rf_waddr, cyc);
      end else begin
        e = sb.pop_front();
        check("rf_wdata", 64'(rf_wdata), 64'(e.lo));
        check("prod_hi", 64'(prod_hi), 64'(e.hi));
        check("rf_waddr", 64'(rf_waddr), 64'(e.dest));
        check("done", 64'(done), 64'd1);
        check("stall_in_wb", 64'(stall), 64'd0);
        check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
      end
    end
  end

  task automatic drive_trigger(input logic [1:0] typ, input logic [AW-1:0] dest, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [IW-1:0] im, input logic [63:0] exp);
    sb_t e;
    mul_trigger = 1'b1;
    mul_type    = typ;
    dest_reg    = dest;
    src1_data   = a;
    src2_data   = b;
    imm         = im;
    e.dest    = dest;
    e.lo      = exp[DW-1:0];
    e.hi      = exp[2*DW-1:DW];
    e.acc_cyc = cyc;
    sb.push_back(e);
    #1;
    check("stall_trigger", 64'(stall), 64'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < LAT + 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no writeback within %0d cycles, pending=%0d", LAT + 20, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [1:0] typ, input logic [AW-1:0] dest, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [IW-1:0] im, input logic [63:0] exp);
    @(negedge clk);
    drive_trigger(typ, dest, a, b, im, exp);
    @(negedge clk);
    mul_trigger = 1'b0;
    wait_done();
  endtask

  initial begin
    int w0;
    vecs[0] = '{2'd0, 4'd3,  32'd6,          32'd0,          16'd7,      32'd42,         32'd0};
    vecs[1] = '{2'd0, 4'd5,  32'd2,          32'd0,          16'hFFFF,   32'h0001FFFE,   32'd0};
    vecs[2] = '{2'd2, 4'd6,  32'd2,          32'd0,          16'hFFFF,   32'hFFFFFFFE,   32'hFFFFFFFF};
    vecs[3] = '{2'd3, 4'd7,  32'hFFFFFFFD,   32'd5,          16'd0,      32'hFFFFFFF1,   32'hFFFFFFFF};
    vecs[4] = '{2'd1, 4'd8,  32'hFFFFFFFD,   32'd5,          16'd0,      32'hFFFFFFF1,   32'h00000004};
    vecs[5] = '{2'd3, 4'd9,  32'h80000000,   32'hFFFFFFFF,   16'd0,      32'h80000000,   32'h00000000};
    vecs[6] = '{2'd1, 4'd15, 32'hFFFFFFFF,   32'hFFFFFFFF,   16'd0,      32'h00000001,   32'hFFFFFFFE};
    vecs[7] = '{2'd3, 4'd0,  32'h80000000,   32'h80000000,   16'd0,      32'h00000000,   32'h40000000};
    vecs[8] = '{2'd1, 4'd1,  32'd0,          32'h12345678,   16'd0,      32'd0,          32'd0};

    rst = 1'b1; mul_trigger = 1'b0; mul_type = 2'd0; dest_reg = '0;
    src1_data = '0; src2_data = '0; imm = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_outputs", {28'd0, rf_waddr, rf_wdata}, 64'd0);
    check("rst_prod_hi", 64'(prod_hi), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].typ, vecs[i].dest, vecs[i].a, vecs[i].b, vecs[i].im, {vecs[i].exp_hi, vecs[i].exp_lo});

    for (int i = 0; i < 6; i++) begin
      logic [1:0]    t;
      logic [DW-1:0] a, b;
      logic [IW-1:0] im;
      t  = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      im = IW'($urandom);
      run_op(t, AW'(i + 2), a, b, im, model(t, a, b, im));
    end

    // Second trigger while busy must be dropped; stall covers cycles 0..LAT-1 only.
    w0 = we_count;
    @(negedge clk);
    drive_trigger(2'd1, 4'd4, 32'd1000, 32'd3000, 16'd0, 64'd3000000);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1)  mul_trigger = 1'b0;
      if (k == 10) begin mul_trigger = 1'b1; dest_reg = 4'd9; src1_data = 32'd7; end
      if (k == 11) mul_trigger = 1'b0;
      #1;
      check($sformatf("stall_c%0d", k), 64'(stall), (k <= LAT - 1) ? 64'd1 : 64'd0);
    end
    wait_done();
    repeat (LAT) @(negedge clk);
    check("single_we_pulse", 64'(we_count - w0), 64'd1);

    // Reset during CALC: no write, outputs cleared, then a fresh op completes normally.
    w0 = we_count;
    @(negedge clk);
    drive_trigger(2'd0, 4'd3, 32'd6, 32'd0, 16'd7, 64'd42);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) mul_trigger = 1'b0;
    end
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_rf_we", 64'(rf_we), 64'd0);
    check("midrst_outputs", {28'd0, rf_waddr, rf_wdata}, 64'd0);
    check("midrst_prod_hi", 64'(prod_hi), 64'd0);
    rst = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    check("midrst_no_write", 64'(we_count - w0), 64'd0);
    run_op(2'd0, 4'd12, 32'd6, 32'd0, 16'd7, 64'd42);
    check("post_rst_write", 64'(we_count - w0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
